clkdiv_ctrl: RTL and testbench

CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

---
 rtl/clkdiv_pkg.sv | 15 +
 rtl/clkdiv_cnt.sv | 33 +++
 rtl/clkdiv_ctrl.sv | 125 ++++++++++++
 tb/tb_clkdiv_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock divider controller: state encoding and
// reset-time defaults for the period/high-time configuration.
package clkdiv_pkg;

    localparam int CLKDIV_W        = 8;
    localparam int CLKDIV_DEF_DIV  = 4;
    localparam int CLKDIV_DEF_HIGH = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

endpackage

// File: rtl/clkdiv_cnt.sv
// Period counter: counts 0..div-1, restarts on load, flags the last cycle
// of the period so the controller can act on the boundary.
module clkdiv_cnt
    import clkdiv_pkg::*;
#(
    parameter int W = CLKDIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] div,
    output logic [W-1:0] cnt,
    output logic         last
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == div - W'(1));

endmodule

// File: rtl/clkdiv_ctrl.sv
// Programmable clock divider / pulse generator with glitch-free
// reconfiguration: new settings only take effect on a period boundary.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int W        = CLKDIV_W,
    parameter int DEF_DIV  = CLKDIV_DEF_DIV,
    parameter int DEF_HIGH = CLKDIV_DEF_HIGH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    input  logic [W-1:0] cfg_high,
    output logic         cfg_ready,
    output logic         clk_out,
    output logic         period_start,
    output logic         busy
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_act_div;
    logic [W-1:0] r_act_high;
    logic [W-1:0] r_pend_div;
    logic [W-1:0] r_pend_high;
    logic         r_pend;
    logic         r_clk_out;

    logic [W-1:0] w_cnt;
    logic [W-1:0] w_cnt_nxt;
    logic [W-1:0] w_div_c;
    logic [W-1:0] w_high_c;
    logic [W-1:0] w_next_high;
    logic         w_last;
    logic         w_load;
    logic         w_accept;
    logic         w_boundary;
    logic         w_swap;

    clkdiv_cnt #(.W(W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .div  (r_act_div),
        .cnt  (w_cnt),
        .last (w_last)
    );

    // High time is clamped against the already-clamped period.
    always_comb begin
        w_div_c  = (cfg_div < W'(2)) ? W'(2) : cfg_div;
        w_high_c = cfg_high;
        if (cfg_high == '0) begin
            w_high_c = W'(1);
        end else if (cfg_high >= w_div_c) begin
            w_high_c = w_div_c - W'(1);
        end
    end

    assign w_accept    = cfg_valid && !r_pend;
    assign w_boundary  = (r_state != ST_IDLE) && w_last;
    assign w_swap      = r_pend && ((r_state == ST_IDLE) || w_boundary);
    assign w_next_high = w_swap ? r_pend_high : r_act_high;
    assign w_load      = (r_state == ST_IDLE) || w_boundary;
    assign w_cnt_nxt   = w_load ? '0 : (w_cnt + W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        cfg_ready    = !r_pend;
        busy         = (r_state != ST_IDLE);
        period_start = (r_state != ST_IDLE) && (w_cnt == '0);
        case (r_state)
            ST_IDLE: if (en) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_last)   w_state_nxt = en ? ST_RUN : ST_IDLE;
                else if (!en) w_state_nxt = ST_STOP;
            end
            ST_STOP: if (w_last) w_state_nxt = en ? ST_RUN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // clk_out is computed from next-cycle count and high time so it stays
    // aligned with cnt, including the first cycle under a new config.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_out <= 1'b0;
        end else begin
            r_clk_out <= (w_state_nxt != ST_IDLE) && (w_cnt_nxt < w_next_high);
        end
    end

    assign clk_out = r_clk_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act_div   <= W'(DEF_DIV);
            r_act_high  <= W'(DEF_HIGH);
            r_pend_div  <= '0;
            r_pend_high <= '0;
            r_pend      <= 1'b0;
        end else if (w_accept) begin
            r_pend_div  <= w_div_c;
            r_pend_high <= w_high_c;
            r_pend      <= 1'b1;
        end else if (w_swap) begin
            r_act_div   <= r_pend_div;
            r_act_high  <= r_pend_high;
            r_pend      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed self-checking bench for clkdiv_ctrl: start-up, reconfiguration
// at period boundaries, clamping, stop/restart and asynchronous reset.
module tb_clkdiv_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_div = '0;
    logic [7:0] cfg_high = '0;
    logic       cfg_ready;
    logic       clk_out;
    logic       period_start;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;

    clkdiv_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_div      (cfg_div),
        .cfg_high     (cfg_high),
        .cfg_ready    (cfg_ready),
        .clk_out      (clk_out),
        .period_start (period_start),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ticks n cycles; bit n-1-i of the vectors is the value expected after tick i.
    task automatic expect_wave(input string tag, input int n,
                               input logic [15:0] co_exp, input logic [15:0] ps_exp);
        for (int i = 0; i < n; i++) begin
            tick();
            check($sformatf("%s_co%0d", tag, i), clk_out, co_exp[n-1-i]);
            check($sformatf("%s_ps%0d", tag, i), period_start, ps_exp[n-1-i]);
        end
    endtask

    task automatic offer(input logic [7:0] d, input logic [7:0] h);
        cfg_valid = 1'b1;
        cfg_div   = d;
        cfg_high  = h;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_co", clk_out, 0);
        check("rst_ps", period_start, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cfg_ready, 1);
        tick(); tick();
        check("rst_held_co", clk_out, 0);
        rst = 1'b0;
        tick();
        check("idle_wait_busy", busy, 0);
        check("idle_wait_co", clk_out, 0);

        // Default 4/1 run: 1,0,0,0 with period_start one cycle after en
        en = 1'b1;
        tick();
        check("start_co", clk_out, 1);
        check("start_ps", period_start, 1);
        check("start_busy", busy, 1);
        expect_wave("def", 7, 16'b0001000, 16'b0001000);

        // 6/3 accepted mid-period; other offers ignored while not ready
        tick();
        check("p4_c0_co", clk_out, 1);
        offer(8'd6, 8'd3);
        tick();
        check("cfg6_ready", cfg_ready, 0);
        check("cfg6_co", clk_out, 0);
        offer(8'd2, 8'd1);
        expect_wave("cfg6_tail", 2, 16'b00, 16'b00);
        check("cfg6_ready_hold", cfg_ready, 0);
        cfg_valid = 1'b0;
        tick();
        check("cfg6_bnd_co", clk_out, 1);
        check("cfg6_bnd_ps", period_start, 1);
        check("cfg6_bnd_ready", cfg_ready, 1);
        expect_wave("p6", 6, 16'b110001, 16'b000001);

        // 1/0 clamps to 2/1
        offer(8'd1, 8'd0);
        tick();
        check("cfg2_ready", cfg_ready, 0);
        check("cfg2_co", clk_out, 1);
        cfg_valid = 1'b0;
        expect_wave("cfg2_tail", 4, 16'b1000, 16'b0000);
        tick();
        check("cfg2_bnd_co", clk_out, 1);
        check("cfg2_bnd_ps", period_start, 1);
        check("cfg2_bnd_ready", cfg_ready, 1);
        expect_wave("p2", 4, 16'b0101, 16'b0101);

        // 5/9 clamps to 5/4
        offer(8'd5, 8'd9);
        tick();
        check("cfg5_co", clk_out, 0);
        check("cfg5_ready", cfg_ready, 0);
        cfg_valid = 1'b0;
        tick();
        check("cfg5_bnd_co", clk_out, 1);
        check("cfg5_bnd_ps", period_start, 1);
        expect_wave("p5", 5, 16'b11101, 16'b00001);

        // Back to 4/1, then en dropped at cnt=1
        offer(8'd4, 8'd1);
        tick();
        check("cfg4_co", clk_out, 1);
        cfg_valid = 1'b0;
        expect_wave("cfg4_tail", 3, 16'b110, 16'b000);
        tick();
        check("cfg4_bnd_co", clk_out, 1);
        check("cfg4_bnd_ps", period_start, 1);
        tick();
        check("stop_c1_co", clk_out, 0);
        en = 1'b0;
        tick();
        check("stop_c2_busy", busy, 1);
        check("stop_c2_co", clk_out, 0);
        tick();
        check("stop_c3_busy", busy, 1);
        tick();
        check("stop_idle_busy", busy, 0);
        check("stop_idle_co", clk_out, 0);
        check("stop_idle_ps", period_start, 0);
        tick();
        check("stop_idle2_busy", busy, 0);

        // Restart, drop en, re-raise at cnt=3 in STOP: no gap
        en = 1'b1;
        tick();
        check("rerun_co", clk_out, 1);
        check("rerun_ps", period_start, 1);
        tick();
        en = 1'b0;
        tick();
        check("rerun_stop_busy", busy, 1);
        tick();
        check("rerun_c3_co", clk_out, 0);
        en = 1'b1;
        tick();
        check("cont_co", clk_out, 1);
        check("cont_ps", period_start, 1);
        check("cont_busy", busy, 1);
        expect_wave("cont", 4, 16'b0001, 16'b0001);

        // Reconfigure to 3/2, park 8/5 as pending, then reset at cnt=0
        expect_wave("pre3", 3, 16'b000, 16'b000);
        offer(8'd3, 8'd2);
        tick();
        check("cfg3_acc_co", clk_out, 1);
        check("cfg3_acc_ready", cfg_ready, 0);
        cfg_valid = 1'b0;
        expect_wave("cfg3_tail", 3, 16'b000, 16'b000);
        tick();
        check("cfg3_bnd_co", clk_out, 1);
        check("cfg3_bnd_ready", cfg_ready, 1);
        tick();
        check("p3_c1_co", clk_out, 1);
        tick();
        check("p3_c2_co", clk_out, 0);
        offer(8'd8, 8'd5);
        tick();
        check("pend8_co", clk_out, 1);
        check("pend8_ready", cfg_ready, 0);
        cfg_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_co", clk_out, 0);
        check("arst_ps", period_start, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", cfg_ready, 1);
        en = 1'b0;
        tick();
        rst = 1'b0;
        tick(); tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_co", clk_out, 0);
        en = 1'b1;
        tick();
        check("post_rst_co0", clk_out, 1);
        check("post_rst_ps0", period_start, 1);
        expect_wave("post_rst", 4, 16'b0001, 16'b0001);

        // Stop, then load 3/2 while IDLE and start with it
        en = 1'b0;
        tick(); tick(); tick(); tick();
        check("idle2_busy", busy, 0);
        check("idle2_co", clk_out, 0);
        offer(8'd3, 8'd2);
        tick();
        check("idle_acc_ready", cfg_ready, 0);
        check("idle_acc_busy", busy, 0);
        cfg_valid = 1'b0;
        tick();
        check("idle_xfer_ready", cfg_ready, 1);
        en = 1'b1;
        tick();
        check("idle3_co", clk_out, 1);
        check("idle3_ps", period_start, 1);
        expect_wave("idle3", 3, 16'b101, 16'b001);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
